// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares a single-port, synchronous-read data memory between
// the CPU load/store path (port 0) and a debug/DMA master (port 1).
// Port 0 has fixed priority, and a starvation guard lets port 1 through.
// Only one transaction is in flight at a time. The block sequences the memory
// read latency and returns a one-cycle ack (plus the read word) to the winner.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   pN_req/we/addr/wdata/wstrb     command of requester N, held until pN_ack
//   pN_ack, pN_rdata               completion pulse and read word for requester N
//   mem_addr, mem_wdata, mem_we    memory command; only mem_we qualifies a write
//   mem_rdata                      memory read word, RD_LAT cycles after issue
//   grant_id, busy                 owner of current/last transaction, FSM not idle
module data_mem_arbiter #(
   parameter int unsigned RD_LAT       = 1,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   input  logic [3:0]  p0_wstrb,
   output logic        p0_ack,
   output logic [31:0] p0_rdata,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   input  logic [3:0]  p1_wstrb,
   output logic        p1_ack,
   output logic [31:0] p1_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_we,
   input  logic [31:0] mem_rdata,
   output logic        grant_id,
   output logic        busy
);

   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned SW  = 4;
   localparam int unsigned CW  = 3;
   localparam int unsigned SCW = 4;

   localparam logic [CW-1:0]  CNT_INIT   = CW'(RD_LAT - 1);
   localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_LIMIT);
   localparam logic [SCW-1:0] STARVE_MAX = '1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [SCW-1:0] starve_q, starve_d;
   logic           we_q, we_d;
   logic           grant_q, grant_d;
   logic [AW-1:0]  mem_addr_q, mem_addr_d;
   logic [DW-1:0]  mem_wdata_q, mem_wdata_d;
   logic [SW-1:0]  mem_we_q, mem_we_d;
   logic           p0_ack_q, p0_ack_d, p1_ack_q, p1_ack_d;
   logic [DW-1:0]  p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
   logic           busy_q, busy_d;

   // Winner selection: port 1 only when port 0 is absent or port 1 has starved long enough
   logic           pick_p1;
   logic           sel_we;
   logic [AW-1:0]  sel_addr;
   logic [DW-1:0]  sel_wdata;
   logic [SW-1:0]  sel_wstrb;

   assign pick_p1   = p1_req && (!p0_req || (starve_q >= STARVE_LIM));
   assign sel_we    = pick_p1 ? p1_we    : p0_we;
   assign sel_addr  = pick_p1 ? p1_addr  : p0_addr;
   assign sel_wdata = pick_p1 ? p1_wdata : p0_wdata;
   assign sel_wstrb = pick_p1 ? p1_wstrb : p0_wstrb;

   // Next state and next values of all registered outputs
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      starve_d    = starve_q;
      we_d        = we_q;
      grant_d     = grant_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = '0;
      p0_ack_d    = 1'b0;
      p1_ack_d    = 1'b0;
      p0_rdata_d  = '0;
      p1_rdata_d  = '0;

      case (state_q)
         S_IDLE: begin
            // Count only arbitrations that port 1 actually lost to port 0
            if (p1_req && !pick_p1) begin
               starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + SCW'(1);
            end else begin
               starve_d = '0;
            end
            if (p0_req || p1_req) begin
               state_d     = S_ISSUE;
               grant_d     = pick_p1;
               we_d        = sel_we;
               mem_addr_d  = {sel_addr[AW-1:2], 2'b00};
               mem_wdata_d = sel_wdata;
               mem_we_d    = sel_we ? sel_wstrb : '0;
            end
         end
         S_ISSUE: begin
            if (we_q) begin
               state_d  = S_DONE;
               p0_ack_d = !grant_q;
               p1_ack_d = grant_q;
            end else begin
               state_d = S_WAIT;
               cnt_d   = CNT_INIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d  = S_DONE;
               p0_ack_d = !grant_q;
               p1_ack_d = grant_q;
               if (grant_q) begin
                  p1_rdata_d = mem_rdata;
               end else begin
                  p0_rdata_d = mem_rdata;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         starve_q    <= '0;
         we_q        <= 1'b0;
         grant_q     <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= '0;
         p0_ack_q    <= 1'b0;
         p1_ack_q    <= 1'b0;
         p0_rdata_q  <= '0;
         p1_rdata_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         starve_q    <= starve_d;
         we_q        <= we_d;
         grant_q     <= grant_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
         p0_ack_q    <= p0_ack_d;
         p1_ack_q    <= p1_ack_d;
         p0_rdata_q  <= p0_rdata_d;
         p1_rdata_q  <= p1_rdata_d;
         busy_q      <= busy_d;
      end
   end

   assign p0_ack    = p0_ack_q;
   assign p1_ack    = p1_ack_q;
   assign p0_rdata  = p0_rdata_q;
   assign p1_rdata  = p1_rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_we    = mem_we_q;
   assign grant_id  = grant_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter. The main instance uses RD_LAT=3 and
// STARVE_LIMIT=4. A second instance uses RD_LAT=1 for the short-latency read case.
module tb_data_mem_arbiter;

   localparam int unsigned RD_LAT       = 3;
   localparam int unsigned STARVE_LIMIT = 4;
   localparam int unsigned MEM_WORDS    = 256;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        mem_clear;
   logic        p0_req, p0_we, p1_req, p1_we;
   logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic [3:0]  p0_wstrb, p1_wstrb;
   logic        p0_ack, p1_ack, grant_id, busy;
   logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_we;

   data_mem_arbiter #(.RD_LAT(RD_LAT), .STARVE_LIMIT(STARVE_LIMIT)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_wstrb(p0_wstrb), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_wstrb(p1_wstrb), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
      .grant_id(grant_id), .busy(busy)
   );

   // Memory attached to the main instance: byte writes, RD_LAT-deep read pipeline
   logic [31:0] mem [MEM_WORDS];
   logic [31:0] rd_pipe [RD_LAT];
   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] <= '0;
      end else begin
         for (int b = 0; b < 4; b++)
            if (mem_we[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      rd_pipe[0] <= mem[mem_addr[9:2]];
      for (int k = 1; k < int'(RD_LAT); k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign mem_rdata = rd_pipe[RD_LAT-1];

   // Second instance with a one-cycle memory
   logic        l_p0_req, l_p0_we, l_p1_req, l_p1_we;
   logic [31:0] l_p0_addr, l_p0_wdata, l_p1_addr, l_p1_wdata;
   logic [3:0]  l_p0_wstrb, l_p1_wstrb;
   logic        l_p0_ack, l_p1_ack, l_grant, l_busy;
   logic [31:0] l_p0_rdata, l_p1_rdata, l_mem_addr, l_mem_wdata, l_mem_rdata;
   logic [3:0]  l_mem_we;

   data_mem_arbiter #(.RD_LAT(1), .STARVE_LIMIT(STARVE_LIMIT)) u_lat1 (
      .clk(clk), .rst_n(rst_n),
      .p0_req(l_p0_req), .p0_we(l_p0_we), .p0_addr(l_p0_addr), .p0_wdata(l_p0_wdata),
      .p0_wstrb(l_p0_wstrb), .p0_ack(l_p0_ack), .p0_rdata(l_p0_rdata),
      .p1_req(l_p1_req), .p1_we(l_p1_we), .p1_addr(l_p1_addr), .p1_wdata(l_p1_wdata),
      .p1_wstrb(l_p1_wstrb), .p1_ack(l_p1_ack), .p1_rdata(l_p1_rdata),
      .mem_addr(l_mem_addr), .mem_wdata(l_mem_wdata), .mem_we(l_mem_we),
      .mem_rdata(l_mem_rdata), .grant_id(l_grant), .busy(l_busy)
   );

   always @(posedge clk)
      l_mem_rdata <= (l_mem_addr == 32'h0000_0200) ? 32'h1234_5678 : 32'h0;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   // One single-port transaction, started at a negedge while the DUT is idle.
   // Once the command has been latched, the requester's addr/wdata inputs are scrambled.
   task automatic run_txn(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          output int lat, output logic [31:0] rdata, output logic [3:0] we_seen,
                          output int we_cycles, output logic [31:0] issue_addr,
                          output logic other_ack);
      lat = -1; rdata = '0; we_seen = '0; we_cycles = 0; issue_addr = '0; other_ack = 1'b0;
      if (port) begin
         p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_wstrb = wstrb;
      end else begin
         p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_wstrb = wstrb;
      end
      for (int n = 1; n <= 20 && lat < 0; n++) begin
         @(negedge clk);
         if (n == 1) begin
            issue_addr = mem_addr;
            if (port) begin p1_addr = ~addr; p1_wdata = ~wdata; end
            else      begin p0_addr = ~addr; p0_wdata = ~wdata; end
         end
         if (mem_we != 4'h0) begin we_seen = mem_we; we_cycles++; end
         if (port ? p0_ack : p1_ack) other_ack = 1'b1;
         if (port ? p1_ack : p0_ack) begin
            lat = n;
            rdata = port ? p1_rdata : p0_rdata;
         end
      end
      p0_req = 1'b0; p1_req = 1'b0;
      @(negedge clk);
   endtask

   typedef struct {
      logic        port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          exp_lat;
      logic [31:0] exp_rdata;
      logic [3:0]  exp_we;
      logic [31:0] exp_maddr;
   } vec_t;

   // Reference model state for the randomized phase
   logic [31:0] ref_mem [MEM_WORDS];
   bit          m_busy;
   int          m_start, m_done;
   logic        m_owner, m_we_l;
   logic [31:0] m_addr_l, m_wdata_l, m_rdata_exp;
   logic [3:0]  m_wstrb_l;
   int          starve;
   logic [31:0] exp_maddr, exp_mwdata;
   logic        exp_grant;
   bit          pend [2];

   initial begin
      vec_t        vecs [10];
      int          lat, we_cycles;
      logic [31:0] rdata, issue_addr;
      logic [3:0]  we_seen;
      logic        other_ack;

      rst_n = 1'b0; mem_clear = 1'b1;
      p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0; p0_wstrb = '0;
      p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0; p1_wstrb = '0;
      l_p0_req = 0; l_p0_we = 0; l_p0_addr = '0; l_p0_wdata = '0; l_p0_wstrb = '0;
      l_p1_req = 0; l_p1_we = 0; l_p1_addr = '0; l_p1_wdata = '0; l_p1_wstrb = '0;

      // Reset values
      @(negedge clk);
      mem_clear = 1'b0;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_p0_ack", 32'(p0_ack), 32'd0);
      check("rst_p1_ack", 32'(p1_ack), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_grant", 32'(grant_id), 32'd0);
      check("rst_p0_rdata", p0_rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // RD_LAT=1 read: ack in cycle 3
      begin
         int l_lat;
         logic [31:0] l_rd;
         l_lat = -1; l_rd = '0;
         l_p0_req = 1'b1; l_p0_we = 1'b0; l_p0_addr = 32'h0000_0200;
         for (int n = 1; n <= 20 && l_lat < 0; n++) begin
            @(negedge clk);
            if (l_p0_ack) begin l_lat = n; l_rd = l_p0_rdata; end
         end
         l_p0_req = 1'b0;
         check("lat1_read_latency", 32'(l_lat), 32'd3);
         check("lat1_read_data", l_rd, 32'h1234_5678);
         @(negedge clk);
      end

      // Single-port transactions. Memory starts cleared; the RD_LAT=3 main instance acks reads in cycle 5.
      vecs[0] = '{1'b0, 1'b1, 32'h0000_0106, 32'hAABB_CCDD, 4'b1100, 2, 32'h0, 4'b1100, 32'h104};
      vecs[1] = '{1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'b1111, 2, 32'h0, 4'b1111, 32'h200};
      vecs[2] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0,         4'b0000, 5, 32'h1234_5678, 4'b0, 32'h200};
      vecs[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,         4'b0000, 5, 32'hAABB_0000, 4'b0, 32'h104};
      vecs[4] = '{1'b1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'b1111, 2, 32'h0, 4'b1111, 32'h040};
      vecs[5] = '{1'b1, 1'b0, 32'h0000_0043, 32'h0,         4'b0000, 5, 32'hCAFE_F00D, 4'b0, 32'h040};
      vecs[6] = '{1'b0, 1'b1, 32'h0000_0200, 32'hFFFF_FFFF, 4'b0000, 2, 32'h0, 4'b0000, 32'h200};
      vecs[7] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0,         4'b0000, 5, 32'h1234_5678, 4'b0, 32'h200};
      vecs[8] = '{1'b1, 1'b1, 32'h0000_0044, 32'h1122_3344, 4'b0101, 2, 32'h0, 4'b0101, 32'h044};
      vecs[9] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         4'b0000, 5, 32'h0022_0044, 4'b0, 32'h044};

      for (int i = 0; i < 10; i++) begin
         run_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                 lat, rdata, we_seen, we_cycles, issue_addr, other_ack);
         check($sformatf("vec%0d_ack_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
         check($sformatf("vec%0d_mem_we", i), 32'(we_seen), 32'(vecs[i].exp_we));
         check($sformatf("vec%0d_mem_we_cycles", i), 32'(we_cycles),
               (vecs[i].exp_we != 4'h0) ? 32'd1 : 32'd0);
         check($sformatf("vec%0d_mem_addr", i), issue_addr, vecs[i].exp_maddr);
         check($sformatf("vec%0d_other_ack", i), 32'(other_ack), 32'd0);
         check($sformatf("vec%0d_grant_id", i), 32'(grant_id), 32'(vecs[i].port));
      end

      // Both ports hold req: port 1 wins every fifth grant
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h300; p0_wdata = 32'h0A0A_0A0A; p0_wstrb = 4'hF;
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h304; p1_wdata = 32'h0B0B_0B0B; p1_wstrb = 4'hF;
      for (int k = 0; k < 10; k++) begin
         logic [1:0] acks;
         acks = 2'b00;
         for (int n = 0; n < 10 && acks == 2'b00; n++) begin
            @(negedge clk);
            acks = {p1_ack, p0_ack};
         end
         check($sformatf("starve_grant%0d", k), 32'(acks), (k % 5 == 4) ? 32'd2 : 32'd1);
      end
      p0_req = 1'b0; p1_req = 1'b0;
      @(negedge clk);

      // Reset during WAIT of a p0 read aborts it
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h200;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_read_busy", 32'(busy), 32'd0);
      check("abort_read_mem_we", 32'(mem_we), 32'd0);
      p0_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int stray;
         stray = 0;
         repeat (8) begin
            @(negedge clk);
            if (p0_ack || p1_ack) stray++;
         end
         check("abort_read_no_ack", 32'(stray), 32'd0);
      end
      run_txn(1'b0, 1'b0, 32'h200, 32'h0, 4'h0, lat, rdata, we_seen, we_cycles, issue_addr, other_ack);
      check("reissue_read_latency", 32'(lat), 32'd5);
      check("reissue_read_data", rdata, 32'h1234_5678);

      // Reset during ISSUE of a write: mem_we drops at once, nothing is written
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h208; p0_wdata = 32'h5555_AAAA; p0_wstrb = 4'hF;
      @(negedge clk);
      check("abort_write_issue_we", 32'(mem_we), 32'hF);
      rst_n = 1'b0;
      #1;
      check("abort_write_mem_we", 32'(mem_we), 32'd0);
      check("abort_write_busy", 32'(busy), 32'd0);
      p0_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_txn(1'b0, 1'b0, 32'h208, 32'h0, 4'h0, lat, rdata, we_seen, we_cycles, issue_addr, other_ack);
      check("abort_write_mem_unchanged", rdata, 32'h0);

      // Randomized traffic against a transaction-timeline reference model
      rst_n = 1'b0; mem_clear = 1'b1;
      p0_req = 1'b0; p1_req = 1'b0;
      for (int i = 0; i < int'(MEM_WORDS); i++) ref_mem[i] = '0;
      m_busy = 0; m_start = 0; m_done = 0; m_owner = 0; m_we_l = 0;
      m_addr_l = '0; m_wdata_l = '0; m_wstrb_l = '0; m_rdata_exp = '0;
      starve = 0; exp_maddr = '0; exp_mwdata = '0; exp_grant = 1'b0;
      pend[0] = 0; pend[1] = 0;
      @(negedge clk);
      mem_clear = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int t = 0; t < 400; t++) begin
         bit          idle_now, e_ack0, e_ack1;
         logic [3:0]  e_we;
         logic        w1;
         @(negedge clk);
         idle_now = !m_busy;
         e_ack0 = m_busy && (t == m_done) && !m_owner;
         e_ack1 = m_busy && (t == m_done) && m_owner;
         e_we   = (m_busy && (t == m_start + 1) && m_we_l) ? m_wstrb_l : 4'h0;
         check("rnd_busy", 32'(busy), 32'(m_busy));
         check("rnd_p0_ack", 32'(p0_ack), 32'(e_ack0));
         check("rnd_p1_ack", 32'(p1_ack), 32'(e_ack1));
         check("rnd_mem_we", 32'(mem_we), 32'(e_we));
         check("rnd_mem_addr", mem_addr, exp_maddr);
         check("rnd_mem_wdata", mem_wdata, exp_mwdata);
         check("rnd_grant_id", 32'(grant_id), 32'(exp_grant));
         if (e_ack0) check("rnd_p0_rdata", p0_rdata, m_we_l ? 32'h0 : m_rdata_exp);
         if (e_ack1) check("rnd_p1_rdata", p1_rdata, m_we_l ? 32'h0 : m_rdata_exp);
         if (m_busy && t == m_done) begin
            m_busy = 0;
            pend[m_owner] = 0;
            if (m_owner) p1_req = 1'b0; else p0_req = 1'b0;
         end
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && $urandom_range(0, 2) == 0) begin
               pend[p] = 1;
               if (p == 0) begin
                  p0_req = 1'b1; p0_we = 1'($urandom_range(0, 1));
                  p0_addr = {22'd0, 8'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
                  p0_wdata = $urandom; p0_wstrb = 4'($urandom_range(0, 15));
               end else begin
                  p1_req = 1'b1; p1_we = 1'($urandom_range(0, 1));
                  p1_addr = {22'd0, 8'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
                  p1_wdata = $urandom; p1_wstrb = 4'($urandom_range(0, 15));
               end
            end
         end
         if (idle_now) begin
            w1 = p1_req && (!p0_req || starve >= int'(STARVE_LIMIT));
            if (p1_req && !w1) starve = (starve >= 15) ? 15 : starve + 1;
            else               starve = 0;
            if (p0_req || p1_req) begin
               m_busy    = 1;
               m_start   = t;
               m_owner   = w1;
               m_we_l    = w1 ? p1_we    : p0_we;
               m_addr_l  = w1 ? p1_addr  : p0_addr;
               m_wdata_l = w1 ? p1_wdata : p0_wdata;
               m_wstrb_l = w1 ? p1_wstrb : p0_wstrb;
               m_done    = t + 2 + (m_we_l ? 0 : int'(RD_LAT));
               exp_maddr  = {m_addr_l[31:2], 2'b00};
               exp_mwdata = m_wdata_l;
               exp_grant  = w1;
               if (m_we_l) begin
                  for (int b = 0; b < 4; b++)
                     if (m_wstrb_l[b]) ref_mem[m_addr_l[9:2]][8*b +: 8] = m_wdata_l[8*b +: 8];
               end else begin
                  m_rdata_exp = ref_mem[m_addr_l[9:2]];
               end
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
